station_cmd_ctrl: RTL

- Consumes station IDs decoded by the barcode receiver (ID, ID_vld) and navigation commands from the UART command path (cmd, cmd_rdy).
- Tracks a destination station and asserts in_transit while moving; drops it when the matching barcode is read or a stop command arrives.
- Sits directly downstream of barcode: owns clr_ID_vld and drives in_transit into the motion controller.

---
 rtl/station_pkg.sv | 14 +
 rtl/buzz_gen.sv | 67 ++++++
 rtl/station_cmd_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/station_pkg.sv
// Shared opcodes, FSM state encoding and default field width for the station command controller.
package station_pkg;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    localparam int DEST_W_DEF = 6;

    typedef enum logic {
        IDLE    = 1'b0,
        TRANSIT = 1'b1
    } state_t;

endpackage

// File: rtl/buzz_gen.sv
// Arrival buzzer: square wave with a BUZZ_DIV-cycle half-period, running for BUZZ_CYC cycles.
module buzz_gen #(
    parameter int BUZZ_DIV = 12500,
    parameter int BUZZ_CYC = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic buzz
);

    localparam int DIV_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BUZZ_DIV - 1);
    localparam logic [24:0]      DUR_LAST = 25'(BUZZ_CYC - 1);

    logic             active_q, active_d;
    logic             buzz_q, buzz_d;
    logic [24:0]      dur_q, dur_d;
    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        active_d = active_q;
        buzz_d   = buzz_q;
        dur_d    = dur_q;
        div_d    = div_q;
        if (abort) begin
            active_d = 1'b0;
            buzz_d   = 1'b0;
        end else if (start) begin
            active_d = 1'b1;
            buzz_d   = 1'b0;
            dur_d    = '0;
            div_d    = '0;
        end else if (active_q) begin
            if (dur_q == DUR_LAST) begin
                active_d = 1'b0;
                buzz_d   = 1'b0;
            end else begin
                dur_d = dur_q + 25'd1;
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    buzz_d = ~buzz_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            buzz_q   <= 1'b0;
            dur_q    <= '0;
            div_q    <= '0;
        end else begin
            active_q <= active_d;
            buzz_q   <= buzz_d;
            dur_q    <= dur_d;
            div_q    <= div_d;
        end
    end

    assign buzz = buzz_q;

endmodule

// File: rtl/station_cmd_ctrl.sv
// Station command controller: tracks the destination from UART commands and barcode reads.
// Optional arrival buzzer enabled by defining ARRIVE_BUZZ_EN.
module station_cmd_ctrl
    import station_pkg::*;
#(
    parameter int DEST_W   = DEST_W_DEF,
    parameter int BUZZ_DIV = 12500,
    parameter int BUZZ_CYC = 25000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        cmd,
    input  logic              cmd_rdy,
    output logic              clr_cmd_rdy,
    input  logic [7:0]        ID,
    input  logic              ID_vld,
    output logic              clr_ID_vld,
    output logic              in_transit,
    output logic [DEST_W-1:0] dest_ID,
    output logic [7:0]        last_ID,
    output logic              buzz,
    output logic              buzz_n
);

    state_t            state_q, state_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [7:0]        last_q, last_d;
    logic              ack_cmd, ack_id;
    logic              buzz_w;

    // Command wins over a simultaneous ID; the ID stays pending for the next cycle.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        last_d  = last_q;
        ack_cmd = 1'b0;
        ack_id  = 1'b0;
        if (cmd_rdy) begin
            ack_cmd = 1'b1;
            if (cmd[7:6] == OP_GO) begin
                dest_d  = cmd[DEST_W-1:0];
                state_d = TRANSIT;
            end else if (cmd[7:6] == OP_STOP) begin
                state_d = IDLE;
            end
        end else if (ID_vld) begin
            ack_id = 1'b1;
            if (ID[7:6] == 2'b00) begin
                last_d = ID;
                if (state_q == TRANSIT && ID[DEST_W-1:0] == dest_q) begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dest_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            last_q  <= last_d;
        end
    end

    // Acknowledges are suppressed while reset is held so a pending flag survives reset.
    assign clr_cmd_rdy = ack_cmd & rst_n;
    assign clr_ID_vld  = ack_id & rst_n;
    assign in_transit  = (state_q == TRANSIT);
    assign dest_ID     = dest_q;
    assign last_ID     = last_q;

`ifdef ARRIVE_BUZZ_EN
    logic arrive, go_cmd;

    assign go_cmd = cmd_rdy && (cmd[7:6] == OP_GO);
    assign arrive = !cmd_rdy && ID_vld && (state_q == TRANSIT) &&
                    (ID[7:6] == 2'b00) && (ID[DEST_W-1:0] == dest_q);

    buzz_gen #(
        .BUZZ_DIV (BUZZ_DIV),
        .BUZZ_CYC (BUZZ_CYC)
    ) u_buzz_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .start (arrive),
        .abort (go_cmd),
        .buzz  (buzz_w)
    );
`else
    assign buzz_w = 1'b0;
`endif

    assign buzz   = buzz_w;
    assign buzz_n = ~buzz_w;

endmodule
